// File: rtl/bus_pkg.sv
// bus_pkg: shared W_* bus widths, register-space boundary and target FSM encoding.
package bus_pkg;
  localparam int W_ADDR_W = 32;
  localparam int W_DATA_W = 32;
  localparam logic [W_ADDR_W-1:0] REG_SPACE_BASE = 32'hFFFF_FFF0;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} bus_state_e;
  function automatic logic in_window(input logic [W_ADDR_W-1:0] addr, input logic [W_ADDR_W-1:0] base,
                                     input int unsigned depth);
    return addr >= base && (addr - base) < W_ADDR_W'(depth) && addr < REG_SPACE_BASE;
  endfunction
endpackage

// File: rtl/bus_ram_array.sv
// bus_ram_array: single-port synchronous RAM, read-before-write, contents not reset.
module bus_ram_array #(
  parameter int DEPTH = 256,
  parameter int DW = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata_o
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdata_i;
    rdata_o <= mem[idx_i];
  end
endmodule

// File: rtl/bus_ram_responder.sv
// bus_ram_responder: W_* bus target serving one RAM read/write per strobe after WAIT_STATES cycles.
module bus_ram_responder import bus_pkg::*; #(
  parameter logic [W_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                W_CLK,
  input  logic                W_RST_N,
  input  logic                W_STB,
  input  logic [W_ADDR_W-1:0] W_ADDR,
  input  logic [W_DATA_W-1:0] W_DATA_O,
  input  logic                W_WRITE,
  output logic [W_DATA_W-1:0] W_DATA_I,
  output logic                W_ACK,
  output logic                W_ERR
);
  localparam int AW = $clog2(DEPTH);
  bus_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d, req_idx, ram_idx;
  logic [W_DATA_W-1:0] data_q, data_d, rdata_q, rdata_d, ram_rdata;
  logic write_q, write_d, hit_q, hit_d, ack_q, ack_d, err_q, err_d, ram_we;
  assign req_idx = AW'(W_ADDR - BASE_ADDR);
  // Address the RAM from the live bus while idle so the read word is ready even with zero wait states.
  assign ram_idx = (state_q == ST_IDLE) ? req_idx : idx_q;
  assign ram_we = state_q == ST_ACK && write_q && hit_q;
  bus_ram_array #(.DEPTH(DEPTH), .DW(W_DATA_W)) u_ram (
    .clk_i(W_CLK), .we_i(ram_we), .idx_i(ram_idx), .wdata_i(data_q), .rdata_o(ram_rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    data_d = data_q;
    write_d = write_q;
    hit_d = hit_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: if (W_STB) begin
        idx_d = req_idx;
        data_d = W_DATA_O;
        write_d = W_WRITE;
        hit_d = in_window(W_ADDR, BASE_ADDR, DEPTH);
        cnt_d = 4'(WAIT_STATES);
        state_d = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = !W_STB ? ST_IDLE : (cnt_q == 4'd1 ? ST_ACK : ST_WAIT);
      end
      ST_ACK: begin
        ack_d = 1'b1;
        err_d = !hit_q;
        rdata_d = !hit_q ? '0 : (write_q ? rdata_q : ram_rdata);
        state_d = ST_HOLD;
      end
      default: state_d = W_STB ? ST_HOLD : ST_IDLE;
    endcase
  end
  always_ff @(posedge W_CLK or negedge W_RST_N) begin
    if (!W_RST_N) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      data_q <= '0;
      write_q <= 1'b0;
      hit_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      data_q <= data_d;
      write_q <= write_d;
      hit_q <= hit_d;
      ack_q <= ack_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign W_DATA_I = rdata_q;
  assign W_ACK = ack_q;
  assign W_ERR = err_q;
endmodule
